blink_req_sched: RTL and testbench
==================================

Name: blink_req_sched

Overview:
- Two-requester scheduler in front of one shared iterative Blink 128/128 tweakable block cipher core.
- Round-robin arbitration between the requesters; one operation in flight at a time.
- Holds the winning plaintext, tweak and direction stable on the core inputs for a fixed core latency.
- Captures the core output and returns it through a valid/ready result port tagged with the requester id.
- Keys (K0/K1) are static configuration wired straight to the core; this block does not touch them.

Parameters:
- N, 128, block width in bits.
- TWEAK, 128, tweak width in bits.
- CORE_LAT, 16, cycles the core needs from stable inputs to valid C (must be >= 1).
- CNT_W, $clog2(CORE_LAT)+1, latency counter width.

Ports:
- clk  input  1  core clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req0_valid  input  1  requester 0 has an operation.
- req0_ready  output  1  requester 0 operation accepted this cycle.
- req0_enc  input  1  1 = encrypt, 0 = decrypt.
- req0_p  input  N  requester 0 input block.
- req0_t  input  TWEAK  requester 0 tweak.
- req1_valid, req1_ready, req1_enc, req1_p, req1_t: same as requester 0, for requester 1.
- core_enc  output  1  direction to core.
- core_p  output  N  block to core.
- core_t  output  TWEAK  tweak to core.
- core_load  output  1  one-cycle pulse marking new operand load into core.
- core_c  input  N  core output block.
- res_valid  output  1  result available.
- res_ready  input  1  consumer accepts result.
- res_data  output  N  result block.
- res_id  output  1  requester that issued the result.
- busy  output  1  state != IDLE.
- ops_done  output  16  completed-operation count; wraps 0xFFFF -> 0.

Behaviour:
- Reset (rst=0, async): state=IDLE.
  - All outputs 0: core_*, core_load, res_valid, res_data, res_id, busy, ops_done, both readys.
  - Round-robin pointer last=1, so requester 0 wins first contention.
  - cnt=0. Any in-flight operation is discarded; no result emitted after reset release.
- FSM states: IDLE, RUN, OUT.
- IDLE:
  - Winner is the only valid requester; if both are valid, the one != last.
  - reqX_ready is combinational: (state==IDLE) && reqX_valid && X is the winner. At most one ready high.
  - On handshake at edge E0: register winner enc/p/t into core_enc/core_p/core_t, set res_id=winner, last=winner, cnt=CORE_LAT-1, core_load=1, go to RUN.
  - No valid requester: remain IDLE, core_* hold their previous values.
- RUN:
  - core_load is 1 only in the first cycle after E0, 0 otherwise.
  - Each edge: if cnt==0, res_data<=core_c, res_valid<=1, ops_done<=ops_done+1, go to OUT; else cnt<=cnt-1.
  - Capture happens at edge E0+CORE_LAT; res_valid is visible from then.
  - Both readys are 0.
  - core_* remain stable for the entire RUN and OUT.
- OUT:
  - res_valid=1; res_data and res_id held stable until handshake.
  - On edge with res_ready=1: res_valid<=0, go to IDLE.
  - A new request can be accepted no earlier than the cycle after that edge (readys are 0 in OUT).
  - Back-to-back throughput is one operation per CORE_LAT+2 cycles when res_ready is held at 1.
- Boundaries:
  - CORE_LAT=1: capture at E0+1, cnt never decrements.
  - res_ready held 0 indefinitely: stay in OUT, no new accepts, requesters stall.
  - A requester dropping valid while not granted has no effect.
  - Valid asserted while busy is ignored until IDLE.
  - Simultaneous valids on consecutive ops alternate 0,1,0,1.
  - ops_done wraps silently.

Test Plan:
- Reset, then req0_valid=1, p=0x0123..CDEF, t=0xAA..AA, enc=1, core model C=p^t after 16 cycles -> req0_ready=1 one cycle; core_load pulse at E0+1 cycle; res_valid at E0+16; res_data=p^t, res_id=0, ops_done=1.
- Both valid continuously, res_ready=1 -> grants 0,1,0,1 across 4 ops; each op spans 18 cycles; ops_done=4.
- res_ready=0 for 20 cycles after result -> res_valid, res_data, res_id stable; req1_ready stays 0; release -> IDLE next cycle, req1 accepted the following cycle.
- Assert rst=0 mid-RUN at cnt=7 -> all outputs 0 immediately, last=1; after release no spurious res_valid; next contended grant goes to req0.
- CORE_LAT=1 build: request at E0 -> res_valid at E0+1, core_c sampled at that edge.
- Preload ops_done=0xFFFF via 65535 ops (or force) -> next completion gives ops_done=0.

Source files
------------

// File: rtl/blink_req_sched.sv
// Two-requester round-robin scheduler in front of one shared iterative Blink
// 128/128 core: one operation in flight, result returned on a tagged valid/ready port.
module blink_req_sched #(
  parameter int N        = 128,
  parameter int TWEAK    = 128,
  parameter int CORE_LAT = 16,
  parameter int CNT_W    = $clog2(CORE_LAT) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic             req0_enc,
  input  logic [N-1:0]     req0_p,
  input  logic [TWEAK-1:0] req0_t,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic             req1_enc,
  input  logic [N-1:0]     req1_p,
  input  logic [TWEAK-1:0] req1_t,
  output logic             core_enc,
  output logic [N-1:0]     core_p,
  output logic [TWEAK-1:0] core_t,
  output logic             core_load,
  input  logic [N-1:0]     core_c,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic             res_id,
  output logic             busy,
  output logic [15:0]      ops_done
);

  typedef enum logic [1:0] {IDLE, RUN, OUT} state_t;

  localparam logic [CNT_W-1:0] LOAD_CNT = CNT_W'(CORE_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic             last;
  logic [CNT_W-1:0] cnt;
  logic             any_valid;
  logic             win;

  // The requester that did not win last time gets priority when both ask.
  always_comb begin
    any_valid  = req0_valid || req1_valid;
    win        = (req0_valid && req1_valid) ? ~last : req1_valid;
    req0_ready = rst && (state == IDLE) && req0_valid && !win;
    req1_ready = rst && (state == IDLE) && req1_valid && win;
    busy       = (state != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_valid) state_nxt = RUN;
      RUN:     if (cnt == '0) state_nxt = OUT;
      OUT:     if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Operands stay registered on the core inputs from accept until the next accept.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      core_enc  <= 1'b0;
      core_p    <= '0;
      core_t    <= '0;
      core_load <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_id    <= 1'b0;
      ops_done  <= '0;
      last      <= 1'b1;
      cnt       <= '0;
    end else begin
      core_load <= 1'b0;
      case (state)
        IDLE: begin
          if (any_valid) begin
            core_enc  <= win ? req1_enc : req0_enc;
            core_p    <= win ? req1_p : req0_p;
            core_t    <= win ? req1_t : req0_t;
            res_id    <= win;
            last      <= win;
            cnt       <= LOAD_CNT;
            core_load <= 1'b1;
          end
        end
        RUN: begin
          if (cnt == '0) begin
            res_data  <= core_c;
            res_valid <= 1'b1;
            ops_done  <= ops_done + 16'd1;
          end else begin
            cnt <= cnt - CNT_ONE;
          end
        end
        OUT: begin
          if (res_ready) res_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_blink_req_sched.sv
// Self-checking bench for blink_req_sched: directed scenarios plus a randomized
// run against a transaction-level reference model; a CORE_LAT=1 build runs alongside.
module tb_blink_req_sched;
  localparam int N   = 128;
  localparam int TW  = 128;
  localparam int LAT = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          req0_valid = 0, req0_enc = 0, req1_valid = 0, req1_enc = 0, res_ready = 0;
  logic [N-1:0]  req0_p = '0, req1_p = '0;
  logic [TW-1:0] req0_t = '0, req1_t = '0;
  logic          req0_ready, req1_ready, core_enc, core_load, res_valid, res_id, busy;
  logic [N-1:0]  core_p, core_c, res_data;
  logic [TW-1:0] core_t;
  logic [15:0]   ops_done;

  logic          b_req0_valid = 0, b_req0_enc = 0, b_req1_valid = 0, b_req1_enc = 0, b_res_ready = 0;
  logic [N-1:0]  b_req0_p = '0, b_req1_p = '0;
  logic [TW-1:0] b_req0_t = '0, b_req1_t = '0;
  logic          b_req0_ready, b_req1_ready, b_core_enc, b_core_load, b_res_valid, b_res_id, b_busy;
  logic [N-1:0]  b_core_p, b_core_c, b_res_data;
  logic [TW-1:0] b_core_t;
  logic [15:0]   b_ops_done;

  int vectors = 0;
  int miscompares = 0;
  logic [7:0]  age = 8'd0;
  logic [31:0] cyc = 32'd0;

  function automatic logic [N-1:0] core_fn(input logic enc, input logic [N-1:0] p, input logic [TW-1:0] t);
    return enc ? (p ^ t) : (p ^ {t[63:0], t[127:64]});
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core stand-ins: the main core only shows the right answer once it has had
  // CORE_LAT-1 cycles after the load pulse; the fast core's answer changes every cycle.
  always @(posedge clk) begin
    cyc <= cyc + 32'd1;
    if (core_load) age <= 8'd1;
    else if (age != 8'd0 && age != 8'hFF) age <= age + 8'd1;
  end
  assign core_c   = (((core_load ? 8'd0 : age) >= 8'(LAT - 1)) ? core_fn(core_enc, core_p, core_t)
                                                                : ~core_fn(core_enc, core_p, core_t));
  assign b_core_c = core_fn(b_core_enc, b_core_p, b_core_t) ^ {96'd0, cyc};

  blink_req_sched #(.N(N), .TWEAK(TW), .CORE_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_enc(req0_enc), .req0_p(req0_p), .req0_t(req0_t),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_enc(req1_enc), .req1_p(req1_p), .req1_t(req1_t),
    .core_enc(core_enc), .core_p(core_p), .core_t(core_t), .core_load(core_load), .core_c(core_c),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_id(res_id),
    .busy(busy), .ops_done(ops_done)
  );

  blink_req_sched #(.N(N), .TWEAK(TW), .CORE_LAT(1)) dut1 (
    .clk(clk), .rst(rst),
    .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_enc(b_req0_enc), .req0_p(b_req0_p), .req0_t(b_req0_t),
    .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_enc(b_req1_enc), .req1_p(b_req1_p), .req1_t(b_req1_t),
    .core_enc(b_core_enc), .core_p(b_core_p), .core_t(b_core_t), .core_load(b_core_load), .core_c(b_core_c),
    .res_valid(b_res_valid), .res_ready(b_res_ready), .res_data(b_res_data), .res_id(b_res_id),
    .busy(b_busy), .ops_done(b_ops_done)
  );

  task automatic do_reset();
    rst = 1'b0;
    req0_valid = 0; req1_valid = 0; res_ready = 0;
    b_req0_valid = 0; b_req1_valid = 0; b_res_ready = 0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req0_valid = 1; req1_valid = 1; res_ready = 1;
    b_req0_valid = 1; b_req1_valid = 1; b_res_ready = 1;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({req0_ready, req1_ready, core_enc, core_load, res_valid, res_id, busy, ops_done} !== 23'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %h expected 0",
               {req0_ready, req1_ready, core_enc, core_load, res_valid, res_id, busy, ops_done});
    end
    vectors++;
    if ({core_p, core_t, res_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_data: got %h expected 0", {core_p, core_t, res_data});
    end
    vectors++;
    if ({b_req0_ready, b_req1_ready, b_core_load, b_res_valid, b_busy, b_ops_done, b_res_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL reset_lat1: got %h expected 0",
               {b_req0_ready, b_req1_ready, b_core_load, b_res_valid, b_busy, b_ops_done, b_res_data});
    end
    req0_valid = 0; req1_valid = 0; res_ready = 0;
    b_req0_valid = 0; b_req1_valid = 0; b_res_ready = 0;
    rst = 1'b1;
  endtask

  task automatic test_single();
    logic [N-1:0] p;
    logic [TW-1:0] t;
    p = {2{64'h0123456789ABCDEF}};
    t = {16{8'hAA}};
    do_reset();
    req0_enc = 1; req0_p = p; req0_t = t; req0_valid = 1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready, busy} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL single_grant: got %b expected 100", {req0_ready, req1_ready, busy});
    end
    @(negedge clk);
    req0_valid = 0;
    #1;
    vectors++;
    if ({req0_ready, core_load, busy, res_id, core_enc, res_valid, core_p, core_t} !== {6'b011010, p, t}) begin
      miscompares++;
      $display("[TB] FAIL single_load: got %b/%h expected 011010/%h",
               {req0_ready, core_load, busy, res_id, core_enc, res_valid}, {core_p, core_t}, {p, t});
    end
    for (int k = 1; k < LAT; k++) begin
      @(negedge clk);
      vectors++;
      if ({core_load, res_valid, busy} !== 3'b001) begin
        miscompares++;
        $display("[TB] FAIL single_run%0d: got %b expected 001", k, {core_load, res_valid, busy});
      end
    end
    @(negedge clk);
    vectors++;
    if ({res_valid, res_id, ops_done, res_data} !== {2'b10, 16'd1, p ^ t}) begin
      miscompares++;
      $display("[TB] FAIL single_result: got %b/%0d/%h expected 10/1/%h",
               {res_valid, res_id}, ops_done, res_data, p ^ t);
    end
    res_ready = 1;
    @(negedge clk);
    vectors++;
    if ({res_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL single_release: got %b expected 00", {res_valid, busy});
    end
    res_ready = 0;
  endtask

  task automatic test_back_to_back();
    int ngrant, nres;
    logic [31:0] gcyc;
    logic [N-1:0] exp0, exp1;
    ngrant = 0; nres = 0; gcyc = 0;
    do_reset();
    req0_enc = 1'($urandom); req0_p = rnd128(); req0_t = rnd128();
    req1_enc = 1'($urandom); req1_p = rnd128(); req1_t = rnd128();
    exp0 = core_fn(req0_enc, req0_p, req0_t);
    exp1 = core_fn(req1_enc, req1_p, req1_t);
    req0_valid = 1; req1_valid = 1; res_ready = 1;
    for (int c = 0; c < 100 && nres < 4; c++) begin
      #1;
      if (req0_ready || req1_ready) begin
        vectors++;
        if ({req0_ready, req1_ready} !== ((ngrant % 2 == 0) ? 2'b10 : 2'b01) ||
            (ngrant > 0 && cyc - gcyc != 32'(LAT + 2))) begin
          miscompares++;
          $display("[TB] FAIL b2b_grant%0d: got readys %b spacing %0d expected id %0d spacing %0d",
                   ngrant, {req0_ready, req1_ready}, cyc - gcyc, ngrant % 2, LAT + 2);
        end
        gcyc = cyc;
        ngrant++;
      end
      if (res_valid && res_ready) begin
        vectors++;
        if ({res_id, res_data} !== {1'(nres % 2), (nres % 2 == 0) ? exp0 : exp1}) begin
          miscompares++;
          $display("[TB] FAIL b2b_result%0d: got id %0d data %h expected id %0d",
                   nres, res_id, res_data, nres % 2);
        end
        nres++;
      end
      @(negedge clk);
    end
    vectors++;
    if (nres != 4 || ngrant != 4 || ops_done !== 16'd4) begin
      miscompares++;
      $display("[TB] FAIL b2b_count: got results %0d grants %0d ops_done %0d expected 4/4/4",
               nres, ngrant, ops_done);
    end
    req0_valid = 0; req1_valid = 0; res_ready = 0;
  endtask

  task automatic test_stall();
    logic seen;
    logic [N-1:0] exp;
    seen = 0;
    do_reset();
    req0_enc = 1; req0_p = rnd128(); req0_t = rnd128(); req0_valid = 1;
    exp = core_fn(req0_enc, req0_p, req0_t);
    @(negedge clk);
    req0_valid = 0;
    req1_enc = 1'($urandom); req1_p = rnd128(); req1_t = rnd128(); req1_valid = 1;
    for (int c = 0; c < 40 && !seen; c++) begin
      @(negedge clk);
      seen = res_valid;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("[TB] FAIL stall_timeout: got res_valid %b expected 1 within 40 cycles", res_valid);
    end
    for (int c = 0; c < 20; c++) begin
      vectors++;
      if ({res_valid, res_id, req1_ready, busy, res_data} !== {4'b1001, exp}) begin
        miscompares++;
        $display("[TB] FAIL stall_hold%0d: got %b/%h expected 1001/%h",
                 c, {res_valid, res_id, req1_ready, busy}, res_data, exp);
      end
      @(negedge clk);
    end
    res_ready = 1;
    @(negedge clk);
    vectors++;
    if ({res_valid, busy, req1_ready, req0_ready} !== 4'b0010) begin
      miscompares++;
      $display("[TB] FAIL stall_release: got %b expected 0010", {res_valid, busy, req1_ready, req0_ready});
    end
    res_ready = 0;
    @(negedge clk);
    vectors++;
    if ({busy, core_load, res_id, core_enc, core_p} !== {3'b111, req1_enc, req1_p}) begin
      miscompares++;
      $display("[TB] FAIL stall_accept1: got %b/%h expected 111%b/%h",
               {busy, core_load, res_id, core_enc}, core_p, req1_enc, req1_p);
    end
    req1_valid = 0;
  endtask

  task automatic test_reset_mid_run();
    do_reset();
    req1_enc = 1; req1_p = rnd128(); req1_t = rnd128(); req1_valid = 1;
    @(negedge clk);
    repeat (8) @(negedge clk);
    vectors++;
    if ({busy, res_valid, req0_ready, req1_ready} !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL midrst_pre: got %b expected 1000", {busy, res_valid, req0_ready, req1_ready});
    end
    req0_valid = 1;
    rst = 1'b0;
    #1;
    vectors++;
    if ({req0_ready, req1_ready, core_enc, core_load, res_valid, res_id, busy, ops_done,
         core_p, core_t, res_data} !== '0) begin
      miscompares++;
      $display("[TB] FAIL midrst_zero: got %h/%h expected 0",
               {req0_ready, req1_ready, core_enc, core_load, res_valid, res_id, busy, ops_done},
               {core_p, core_t, res_data});
    end
    @(negedge clk);
    rst = 1'b1; req0_valid = 0; req1_valid = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      vectors++;
      if ({res_valid, busy} !== 2'b00) begin
        miscompares++;
        $display("[TB] FAIL midrst_quiet%0d: got %b expected 00", c, {res_valid, busy});
      end
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    vectors++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL midrst_first: got %b expected 10", {req0_ready, req1_ready});
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  // Transaction-level model: an operation occupies the engine from its grant
  // until its result is taken; the result appears LAT cycles after the grant.
  task automatic test_random();
    logic m_out, m_id, m_enc, m_last, w, e_r0, e_r1;
    logic [N-1:0] m_p, m_data;
    logic [TW-1:0] m_t;
    logic [15:0] m_ops;
    int m_age;
    m_out = 0; m_id = 0; m_enc = 0; m_last = 1; m_p = '0; m_t = '0; m_data = '0; m_ops = 0; m_age = 0;
    do_reset();
    for (int c = 0; c < 800; c++) begin
      req0_valid = ($urandom_range(0, 3) != 0);
      req1_valid = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 1) == 1) begin
        req0_enc = 1'($urandom); req0_p = rnd128(); req0_t = rnd128();
        req1_enc = 1'($urandom); req1_p = rnd128(); req1_t = rnd128();
      end
      res_ready = ($urandom_range(0, 2) != 0);
      #1;
      w = (req0_valid && req1_valid) ? !m_last : req1_valid;
      e_r0 = !m_out && req0_valid && !w;
      e_r1 = !m_out && req1_valid && w;
      vectors++;
      if ({req0_ready, req1_ready, busy, res_valid, core_load, ops_done} !==
          {e_r0, e_r1, m_out, m_out && m_age >= LAT, m_out && m_age == 0, m_ops}) begin
        miscompares++;
        $display("[TB] FAIL rand_ctrl%0d: got %b/%0d expected %b/%0d", c,
                 {req0_ready, req1_ready, busy, res_valid, core_load}, ops_done,
                 {e_r0, e_r1, m_out, m_out && m_age >= LAT, m_out && m_age == 0}, m_ops);
      end
      if (m_out) begin
        vectors++;
        if ({core_enc, res_id, core_p, core_t} !== {m_enc, m_id, m_p, m_t} ||
            (m_age >= LAT && res_data !== m_data)) begin
          miscompares++;
          $display("[TB] FAIL rand_data%0d: got %b%b/%h expected %b%b/%h", c,
                   core_enc, res_id, res_data, m_enc, m_id, m_data);
        end
      end
      if (!m_out) begin
        if (req0_valid || req1_valid) begin
          m_out = 1; m_id = w; m_last = w; m_age = 0;
          m_enc = w ? req1_enc : req0_enc;
          m_p = w ? req1_p : req0_p;
          m_t = w ? req1_t : req0_t;
          m_data = core_fn(m_enc, m_p, m_t);
        end
      end else if (m_age >= LAT && res_ready) begin
        m_out = 0;
      end else begin
        m_age++;
        if (m_age == LAT) m_ops = m_ops + 16'd1;
      end
      @(negedge clk);
    end
    req0_valid = 0; req1_valid = 0; res_ready = 0;
  endtask

  task automatic test_lat1();
    logic [N-1:0] exp;
    do_reset();
    b_req1_enc = 1'($urandom); b_req1_p = rnd128(); b_req1_t = rnd128(); b_req1_valid = 1;
    #1;
    vectors++;
    if ({b_req1_ready, b_req0_ready} !== 2'b10) begin
      miscompares++;
      $display("[TB] FAIL lat1_grant: got %b expected 10", {b_req1_ready, b_req0_ready});
    end
    @(negedge clk);
    b_req1_valid = 0;
    #1;
    exp = core_fn(b_req1_enc, b_req1_p, b_req1_t) ^ {96'd0, cyc};
    vectors++;
    if ({b_core_load, b_res_valid, b_busy} !== 3'b101) begin
      miscompares++;
      $display("[TB] FAIL lat1_load: got %b expected 101", {b_core_load, b_res_valid, b_busy});
    end
    @(negedge clk);
    vectors++;
    if ({b_res_valid, b_res_id, b_ops_done, b_res_data} !== {2'b11, 16'd1, exp}) begin
      miscompares++;
      $display("[TB] FAIL lat1_result: got %b/%0d/%h expected 11/1/%h",
               {b_res_valid, b_res_id}, b_ops_done, b_res_data, exp);
    end
    b_res_ready = 1; b_req0_valid = 1; b_req1_valid = 1;
    #1;
    vectors++;
    if ({b_req0_ready, b_req1_ready} !== 2'b00) begin
      miscompares++;
      $display("[TB] FAIL lat1_busy_ready: got %b expected 00", {b_req0_ready, b_req1_ready});
    end
    @(negedge clk);
    vectors++;
    if ({b_req0_ready, b_req1_ready, b_res_valid} !== 3'b100) begin
      miscompares++;
      $display("[TB] FAIL lat1_next: got %b expected 100", {b_req0_ready, b_req1_ready, b_res_valid});
    end
    b_req0_valid = 0; b_req1_valid = 0; b_res_ready = 0;
  endtask

  task automatic test_wrap();
    do_reset();
    force dut1.ops_done = 16'hFFFF;
    #1;
    release dut1.ops_done;
    b_req0_enc = 1; b_req0_p = rnd128(); b_req0_t = rnd128(); b_req0_valid = 1; b_res_ready = 1;
    @(negedge clk);
    b_req0_valid = 0;
    @(negedge clk);
    vectors++;
    if ({b_res_valid, b_ops_done} !== {1'b1, 16'd0}) begin
      miscompares++;
      $display("[TB] FAIL wrap_zero: got %b/%h expected 1/0000", b_res_valid, b_ops_done);
    end
    @(negedge clk);
    b_req1_valid = 1;
    @(negedge clk);
    b_req1_valid = 0;
    @(negedge clk);
    vectors++;
    if ({b_res_valid, b_res_id, b_ops_done} !== {2'b11, 16'd1}) begin
      miscompares++;
      $display("[TB] FAIL wrap_next: got %b/%h expected 11/0001", {b_res_valid, b_res_id}, b_ops_done);
    end
    b_res_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_stall();
    test_reset_mid_run();
    test_random();
    test_lat1();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
